// File: rtl/fir_sample_feeder_pkg.sv
// Shared types and arithmetic for the FIR sample front end.
// Holds the FSM encoding and saturation helpers.
`timescale 1ns/1ps
package fir_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam logic [DATA_W-1:0] SAT_MAX = 16'h7fff;
    localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

    // a - b clamped to the signed range of a w-bit word
    function automatic longint sat_sub(
        input longint a,
        input longint b,
        input int     w
    );
        longint d;
        longint hi;
        longint lo;
        d  = a - b;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (d > hi)      return hi;
        else if (d < lo) return lo;
        else             return d;
    endfunction

endpackage

// File: rtl/fir_sample_feeder_if.sv
// Write-side link from the feeder into the CDC sample FIFO.
// The feeder is the master; fifo_full is the back-pressure.
`timescale 1ns/1ps
interface fir_sample_feeder_if #(
    parameter int DATA_W = 16
);
    logic              valid_out;
    logic [DATA_W-1:0] dout;
    logic              fifo_full;

    modport master (
        output valid_out,
        output dout,
        input  fifo_full
    );

    modport slave (
        input  valid_out,
        input  dout,
        output fifo_full
    );
endinterface

// File: rtl/fir_sample_feeder_sync_buf.sv
// Small single-clock FIFO; pointers carry an extra MSB
// so full and empty are distinguishable.
`timescale 1ns/1ps
module fir_sync_buf #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk1,
    input  logic              rstn,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_q;
    logic [AW:0]       rd_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_q[AW-1:0]] <= din_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_sample_feeder.sv
// ADC front end: offset removal with saturation, warmup discard,
// local buffering toward the CDC FIFO and overflow statistics.
`timescale 1ns/1ps
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int DATA_W         = fir_pkg::DATA_W,
    parameter int BUF_DEPTH      = 4,
    parameter int WARMUP_SAMPLES = 8,
    parameter int DROP_W         = 16
) (
    input  logic              clk1,
    input  logic              rstn,
    input  logic              enable,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [DATA_W-1:0] offset,
    input  logic              clr_stats,
    fir_sample_feeder_if.master ds,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              overflow
);
    localparam int CW = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;
    localparam int WL = (WARMUP_SAMPLES > 0) ? WARMUP_SAMPLES - 1 : 0;

    state_e            state_q;
    logic [CW-1:0]     warm_q;
    logic              stg_v_q;
    logic [DATA_W-1:0] stg_q;
    logic [DATA_W-1:0] stg_d;
    logic [DATA_W-1:0] last_q;
    logic [DROP_W-1:0] drop_cnt_q;
    logic              ovf_q;

    logic              accept;
    logic              warm_last;
    logic              push;
    logic              pop;
    logic              drop;
    logic              buf_full;
    logic              buf_empty;
    logic [DATA_W-1:0] head;

    assign stg_d = DATA_W'(sat_sub(longint'($signed(adc_data)),
                                   longint'($signed(offset)),
                                   DATA_W));

    assign accept    = (state_q == RUN) && enable && adc_valid;
    assign warm_last = (warm_q == CW'(WL));

    assign pop  = !buf_empty && !ds.fifo_full;
    assign push = stg_v_q && (!buf_full || pop);
    assign drop = stg_v_q && buf_full && !pop;

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            warm_q  <= '0;
            stg_v_q <= 1'b0;
            stg_q   <= '0;
        end else begin
            stg_v_q <= accept;
            if (accept) begin
                stg_q <= stg_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        warm_q  <= '0;
                        state_q <= (WARMUP_SAMPLES == 0) ? RUN : WARMUP;
                    end
                end
                WARMUP: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (adc_valid) begin
                        if (warm_last) begin
                            state_q <= RUN;
                            warm_q  <= '0;
                        end else begin
                            warm_q <= warm_q + CW'(1);
                        end
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // clearing wins over a same-edge drop
    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else if (clr_stats) begin
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else if (drop) begin
            if (!(&drop_cnt_q)) begin
                drop_cnt_q <= drop_cnt_q + DROP_W'(1);
            end
            ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            last_q <= '0;
        end else if (pop) begin
            last_q <= head;
        end
    end

    fir_sync_buf #(
        .DEPTH  (BUF_DEPTH),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk1    (clk1),
        .rstn    (rstn),
        .push_i  (push),
        .din_i   (stg_q),
        .pop_i   (pop),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .head_o  (head)
    );

    assign ds.valid_out = !buf_empty;
    assign ds.dout      = buf_empty ? last_q : head;
    assign busy         = (state_q != IDLE) || !buf_empty;
    assign drop_cnt     = drop_cnt_q;
    assign overflow     = ovf_q;

endmodule
